// File: rtl/wfg_stim_sram.sv
// Stimulus source for the wfg core: walks an SRAM address window with a stride and
// streams the read words out over a valid/ready link through a small prefetch FIFO.
module wfg_stim_sram #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en_i,
    input  logic [ADDR_W-1:0] cfg_start_i,
    input  logic [ADDR_W-1:0] cfg_end_i,
    input  logic [7:0]        cfg_inc_i,
    output logic              csb_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] dout_i,
    output logic [DATA_W-1:0] wfg_axis_tdata_o,
    output logic              wfg_axis_tvalid_o,
    input  logic              wfg_axis_tready_i,
    output logic              busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   start_r, end_r, ptr_r;
    logic [7:0]          inc_r;
    logic                csb_r, inflight_r, tvalid_r, busy_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r;
    logic [DATA_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   tdata_r;

    logic                latch_s, run_s, issue_s, push_s, pop_s, wrap_s;
    logic [CNT_W:0]      credit_s;
    logic [CNT_W-1:0]    cnt_pop_s, cnt_nxt_s;
    logic [PTR_W-1:0]    rd_nxt_s, wr_nxt_s;
    logic [7:0]          inc_eff_s;
    logic [ADDR_W:0]     sum_s;
    logic [ADDR_W-1:0]   ptr_nxt_s, addr_nxt_s;
    logic [DATA_W-1:0]   tdata_nxt_s;

    // FSM next-state: enable starts a run, dropping it stops and flushes
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_en_i) begin
                    state_nxt_s = ST_RUN;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ctrl_en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: read credit, address walk, FIFO bookkeeping and next output values
    always_comb begin
        run_s     = (state_r == ST_RUN) && ctrl_en_i;
        // each in-flight read owns a FIFO slot, so a push can never overflow
        credit_s  = {1'b0, cnt_r} + (CNT_W+1)'(inflight_r);
        issue_s   = run_s && (credit_s < DEPTH_C);
        push_s    = run_s && inflight_r;
        pop_s     = tvalid_r && wfg_axis_tready_i;

        inc_eff_s = (inc_r == 8'd0) ? 8'd1 : inc_r;
        sum_s     = {1'b0, ptr_r} + (ADDR_W+1)'(inc_eff_s);
        wrap_s    = sum_s[ADDR_W] || (sum_s[ADDR_W-1:0] > end_r);

        if (latch_s) begin
            ptr_nxt_s = cfg_start_i;
        end else if (issue_s) begin
            ptr_nxt_s = wrap_s ? start_r : sum_s[ADDR_W-1:0];
        end else begin
            ptr_nxt_s = ptr_r;
        end

        if (issue_s) begin
            addr_nxt_s = ptr_r;
        end else begin
            addr_nxt_s = addr_r;
        end

        cnt_pop_s = cnt_r - CNT_W'(pop_s);
        if (run_s) begin
            cnt_nxt_s = cnt_pop_s + CNT_W'(push_s);
            rd_nxt_s  = rd_ptr_r + PTR_W'(pop_s);
            wr_nxt_s  = wr_ptr_r + PTR_W'(push_s);
        end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
            rd_nxt_s  = {PTR_W{1'b0}};
            wr_nxt_s  = {PTR_W{1'b0}};
        end

        // head bypass: when the FIFO drains to zero this edge, the new head is the word being pushed
        if (cnt_nxt_s == {CNT_W{1'b0}}) begin
            tdata_nxt_s = tdata_r;
        end else if (cnt_pop_s == {CNT_W{1'b0}}) begin
            tdata_nxt_s = dout_i;
        end else begin
            tdata_nxt_s = fifo_mem_r[rd_nxt_s];
        end
    end

    // Control, address and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            start_r    <= {ADDR_W{1'b0}};
            end_r      <= {ADDR_W{1'b0}};
            inc_r      <= 8'd0;
            ptr_r      <= {ADDR_W{1'b0}};
            csb_r      <= 1'b1;
            addr_r     <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            tdata_r    <= {DATA_W{1'b0}};
            tvalid_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            if (latch_s) begin
                start_r <= cfg_start_i;
                end_r   <= cfg_end_i;
                inc_r   <= cfg_inc_i;
            end
            ptr_r      <= ptr_nxt_s;
            csb_r      <= ~issue_s;
            addr_r     <= addr_nxt_s;
            inflight_r <= issue_s;
            cnt_r      <= cnt_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            wr_ptr_r   <= wr_nxt_s;
            tdata_r    <= tdata_nxt_s;
            tvalid_r   <= (cnt_nxt_s != {CNT_W{1'b0}});
            busy_r     <= (state_nxt_s == ST_RUN);
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= dout_i;
        end
    end

    assign csb_o             = csb_r;
    assign addr_o            = addr_r;
    assign wfg_axis_tdata_o  = tdata_r;
    assign wfg_axis_tvalid_o = tvalid_r;
    assign busy_o            = busy_r;

endmodule

// File: tb/tb_wfg_stim_sram.sv
// Directed and scoreboarded bench for wfg_stim_sram with a falling-edge SRAM model.
module tb_wfg_stim_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_en;
    logic [9:0]  cfg_start, cfg_end;
    logic [7:0]  cfg_inc;
    logic        csb;
    logic [9:0]  addr;
    logic [31:0] dout;
    logic [31:0] tdata;
    logic        tvalid, tready, busy;

    logic [31:0] mem [1024];
    int          n_checks = 0;
    int          n_errors = 0;

    bit          mon_on = 1'b0;
    int          sb_start, sb_end, sb_inc;
    int          iss_addr, pop_addr, pops;

    wfg_stim_sram dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ctrl_en_i         (ctrl_en),
        .cfg_start_i       (cfg_start),
        .cfg_end_i         (cfg_end),
        .cfg_inc_i         (cfg_inc),
        .csb_o             (csb),
        .addr_o            (addr),
        .dout_i            (dout),
        .wfg_axis_tdata_o  (tdata),
        .wfg_axis_tvalid_o (tvalid),
        .wfg_axis_tready_i (tready),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    // SRAM model: read on the falling edge while selected
    always @(negedge clk) begin
        if (!csb) dout <= mem[addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int adv(input int p);
        int step;
        int n;
        step = (sb_inc == 0) ? 1 : sb_inc;
        n = p + step;
        if (n > 1023 || n > sb_end) return sb_start;
        return n;
    endfunction

    // Scoreboard: issued addresses and accepted samples follow the window walk
    always @(negedge clk) begin
        if (mon_on) begin
            if (!csb) begin
                check("sb_addr", 64'(addr), 64'(iss_addr));
                iss_addr = adv(iss_addr);
            end
            if (tvalid && tready) begin
                check("sb_data", 64'(tdata), 64'(32'hC0DE_0000 | pop_addr));
                pop_addr = adv(pop_addr);
                pops++;
            end
        end
    end

    task automatic run_seq(input string tag, input logic [9:0] s, input logic [9:0] e,
                           input logic [7:0] inc, input logic [9:0] a0, input logic [9:0] a1,
                           input logic [9:0] a2, input logic [9:0] a3);
        logic [9:0] av [4];
        av[0] = a0; av[1] = a1; av[2] = a2; av[3] = a3;
        cfg_start = s; cfg_end = e; cfg_inc = inc;
        tready = 1'b1;
        ctrl_en = 1'b1;
        tick();
        // changes while running must be ignored
        cfg_start = 10'd511; cfg_end = 10'd600; cfg_inc = 8'd5;
        for (int k = 0; k < 4; k++) begin
            tick();
            check({tag, "_csb"}, 64'(csb), 64'(1'b0));
            check({tag, "_addr"}, 64'(addr), 64'(av[k]));
            if (k > 0) check({tag, "_data"}, 64'(tdata), 64'(32'hC0DE_0000 | av[k-1]));
        end
        tick();
        check({tag, "_last"}, 64'(tdata), 64'(32'hC0DE_0000 | av[3]));
        ctrl_en = 1'b0;
        tick();
    endtask

    initial begin
        int cnt;
        int cycles;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        rst_n = 1'b0; ctrl_en = 1'b0; tready = 1'b0;
        cfg_start = 10'd0; cfg_end = 10'd0; cfg_inc = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_csb", 64'(csb), 64'(1'b1));
        check("rst_addr", 64'(addr), 64'(10'd0));
        check("rst_tvalid", 64'(tvalid), 64'(1'b0));
        check("rst_tdata", 64'(tdata), 64'(32'd0));
        check("rst_busy", 64'(busy), 64'(1'b0));

        // 1: contiguous window, latency and one sample per clock
        cfg_start = 10'd0; cfg_end = 10'd3; cfg_inc = 8'd1; tready = 1'b1; ctrl_en = 1'b1;
        tick();
        check("t1_busy", 64'(busy), 64'(1'b1));
        check("t1_e0_valid", 64'(tvalid), 64'(1'b0));
        check("t1_e0_csb", 64'(csb), 64'(1'b1));
        tick();
        check("t1_e1_csb", 64'(csb), 64'(1'b0));
        check("t1_e1_addr", 64'(addr), 64'(10'd0));
        check("t1_e1_valid", 64'(tvalid), 64'(1'b0));
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t1_valid", 64'(tvalid), 64'(1'b1));
            check("t1_data", 64'(tdata), 64'(32'hC0DE_0000 | (k % 4)));
        end
        ctrl_en = 1'b0;
        tick();
        check("t1_stop_valid", 64'(tvalid), 64'(1'b0));
        check("t1_stop_csb", 64'(csb), 64'(1'b1));
        check("t1_stop_busy", 64'(busy), 64'(1'b0));

        // 2: strided window with wrap
        run_seq("t2", 10'd2, 10'd9, 8'd3, 10'd2, 10'd5, 10'd8, 10'd2);

        // 3: backpressure fills exactly FIFO_DEPTH, then drains without gaps
        cfg_start = 10'd0; cfg_end = 10'd3; cfg_inc = 8'd1; tready = 1'b0; ctrl_en = 1'b1;
        tick();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!csb) cnt++;
        end
        check("t3_reads", 64'(cnt), 64'(4));
        check("t3_csb_idle", 64'(csb), 64'(1'b1));
        check("t3_hold_valid", 64'(tvalid), 64'(1'b1));
        check("t3_hold_data", 64'(tdata), 64'(32'hC0DE_0000));
        tready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_drain_valid", 64'(tvalid), 64'(1'b1));
            check("t3_drain_data", 64'(tdata), 64'(32'hC0DE_0000 | (k % 4)));
        end
        ctrl_en = 1'b0;
        tick();

        // 4: stop with three queued entries, restart at a new window start
        cfg_start = 10'd4; cfg_end = 10'd8; cfg_inc = 8'd1; tready = 1'b0; ctrl_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("t4_queued_data", 64'(tdata), 64'(32'hC0DE_0004));
        ctrl_en = 1'b0;
        tick();
        check("t4_stop_valid", 64'(tvalid), 64'(1'b0));
        check("t4_stop_csb", 64'(csb), 64'(1'b1));
        cfg_start = 10'd6; tready = 1'b1; ctrl_en = 1'b1;
        tick();
        check("t4_flushed", 64'(tvalid), 64'(1'b0));
        tick();
        check("t4_re_addr", 64'(addr), 64'(10'd6));
        tick();
        check("t4_re_valid", 64'(tvalid), 64'(1'b1));
        check("t4_re_data", 64'(tdata), 64'(32'hC0DE_0006));
        tick();
        check("t4_re_data2", 64'(tdata), 64'(32'hC0DE_0007));
        ctrl_en = 1'b0;
        tick();

        // 5: top-of-memory overflow, inverted window, zero stride
        run_seq("t5_ovf", 10'd1020, 10'd1023, 8'd2, 10'd1020, 10'd1022, 10'd1020, 10'd1022);
        run_seq("t5_inv", 10'd7, 10'd5, 8'd1, 10'd7, 10'd7, 10'd7, 10'd7);
        run_seq("t5_inc0", 10'd0, 10'd3, 8'd0, 10'd0, 10'd1, 10'd2, 10'd3);

        // 6a: asynchronous reset in the middle of a burst
        cfg_start = 10'd3; cfg_end = 10'd200; cfg_inc = 8'd7; tready = 1'b1; ctrl_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_csb", 64'(csb), 64'(1'b1));
        check("t6_rst_addr", 64'(addr), 64'(10'd0));
        check("t6_rst_valid", 64'(tvalid), 64'(1'b0));
        check("t6_rst_data", 64'(tdata), 64'(32'd0));
        check("t6_rst_busy", 64'(busy), 64'(1'b0));
        ctrl_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_no_access", 64'(csb), 64'(1'b1));
        end

        // 6b: random backpressure, scoreboard against the address walk
        sb_start = 3; sb_end = 200; sb_inc = 7;
        iss_addr = 3; pop_addr = 3; pops = 0;
        mon_on = 1'b1;
        ctrl_en = 1'b1;
        cycles = 0;
        while (pops < 10000 && cycles < 60000) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        mon_on = 1'b0;
        check("t6_rand_done", 64'(pops >= 10000), 64'(1'b1));
        ctrl_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
